button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/breakout_pkg.sv | 14 +
 rtl/debounce_filter.sv | 74 +++++++
 rtl/button_conditioner.sv | 64 ++++++
 tb/tb_button_conditioner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared constants for the breakout game front end: system clock rate and
// button debounce window, plus the counter-width helper used by the filters.
package breakout_pkg;

    localparam int CLK_HZ              = 40000000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Bits needed to hold any value 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One button path: two-flop synchronizer, saturating debounce counter, stable
// level and a sticky press flag that is cleared by i_consume.
module debounce_filter
    import breakout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_consume,
    output logic o_level
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_hit;
    logic w_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // w_hit marks the cycle on which the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        w_differ = r_sync2 ^ r_stable;
        w_hit    = w_differ && (r_cnt == CNT_LAST);
        w_rise   = w_hit && !r_stable;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            if (!w_differ || w_hit) begin
                r_cnt <= '0;
            end else if (r_cnt < CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_hit) begin
                r_stable <= ~r_stable;
            end
        end
    end

    // Consume wins over a coincident rise; the rise is reported via o_level instead.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky <= 1'b0;
        end else if (i_consume) begin
            r_sticky <= 1'b0;
        end else if (w_rise) begin
            r_sticky <= 1'b1;
        end
    end

    assign o_level = r_stable | r_sticky | w_rise;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the two game buttons and samples them on START_UPDATE.
// Optional macro BTN_CONFLICT_CANCEL_EN: both-pressed samples load 0 on both outputs.
module button_conditioner
    import breakout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_LEFT_RAW,
    input  logic BTN_RIGHT_RAW,
    input  logic START_UPDATE,
    output logic BTN_LEFT,
    output logic BTN_RIGHT
);

    logic w_left_lvl;
    logic w_right_lvl;
    logic w_left_load;
    logic w_right_load;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_left (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_raw     (BTN_LEFT_RAW),
        .i_consume (START_UPDATE),
        .o_level   (w_left_lvl)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_right (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_raw     (BTN_RIGHT_RAW),
        .i_consume (START_UPDATE),
        .o_level   (w_right_lvl)
    );

    always_comb begin
        w_left_load  = w_left_lvl;
        w_right_load = w_right_lvl;
`ifdef BTN_CONFLICT_CANCEL_EN
        if (w_left_lvl && w_right_lvl) begin
            w_left_load  = 1'b0;
            w_right_load = 1'b0;
        end
`endif
    end

    // Outputs only move on update samples so game logic sees a frame-constant view.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BTN_LEFT  <= 1'b0;
            BTN_RIGHT <= 1'b0;
        end else if (START_UPDATE) begin
            BTN_LEFT  <= w_left_load;
            BTN_RIGHT <= w_right_load;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 8.
module tb_button_conditioner;

    localparam int N = 8;
`ifdef BTN_CONFLICT_CANCEL_EN
    localparam logic EXP_CONFLICT = 1'b0;
`else
    localparam logic EXP_CONFLICT = 1'b1;
`endif

    logic CLK;
    logic RST_N;
    logic BTN_LEFT_RAW;
    logic BTN_RIGHT_RAW;
    logic START_UPDATE;
    logic BTN_LEFT;
    logic BTN_RIGHT;

    int tests_run;
    int tests_failed;

    button_conditioner #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .BTN_LEFT_RAW  (BTN_LEFT_RAW),
        .BTN_RIGHT_RAW (BTN_RIGHT_RAW),
        .START_UPDATE  (START_UPDATE),
        .BTN_LEFT      (BTN_LEFT),
        .BTN_RIGHT     (BTN_RIGHT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Leaves the bench 1 time unit after a rising edge.
    task automatic cycle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse();
        START_UPDATE = 1'b1;
        cycle(1);
        START_UPDATE = 1'b0;
    endtask

    task automatic idle_clear();
        BTN_LEFT_RAW  = 1'b0;
        BTN_RIGHT_RAW = 1'b0;
        cycle(15);
        pulse();
        pulse();
    endtask

    task automatic test_reset();
        RST_N         = 1'b0;
        BTN_LEFT_RAW  = 1'b1;
        BTN_RIGHT_RAW = 1'b1;
        START_UPDATE  = 1'b1;
        cycle(4);
        tests_run++;
        if (BTN_LEFT !== 1'b0 || BTN_RIGHT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b%b expected 00", BTN_LEFT, BTN_RIGHT);
        end
        START_UPDATE  = 1'b0;
        RST_N         = 1'b1;
        BTN_RIGHT_RAW = 1'b0;
        cycle(8);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_early_update: got %b expected 0", BTN_LEFT);
        end
        cycle(3);
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold_before_update: got %b expected 0", BTN_LEFT);
        end
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b1 || BTN_RIGHT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_report: got %b%b expected 10", BTN_LEFT, BTN_RIGHT);
        end
        idle_clear();
    endtask

    task automatic test_bounce();
        for (int s = 0; s < 20; s++) begin
            BTN_LEFT_RAW = (s % 2 == 0);
            cycle(3);
        end
        BTN_LEFT_RAW = 1'b1;
        cycle(4);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_filtered: got %b expected 0", BTN_LEFT);
        end
        cycle(11);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce_settled: got %b expected 1", BTN_LEFT);
        end
        idle_clear();
    endtask

    task automatic test_short_press();
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_before: got %b expected 0", BTN_LEFT);
        end
        cycle(50);
        BTN_LEFT_RAW = 1'b1;
        cycle(20);
        BTN_LEFT_RAW = 1'b0;
        cycle(129);
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_held_between: got %b expected 0", BTN_LEFT);
        end
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_sticky_report: got %b expected 1", BTN_LEFT);
        end
        cycle(199);
        tests_run++;
        if (BTN_LEFT !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_held_interval: got %b expected 1", BTN_LEFT);
        end
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_cleared: got %b expected 0", BTN_LEFT);
        end
    endtask

    task automatic test_hold();
        BTN_RIGHT_RAW = 1'b1;
        cycle(12);
        for (int k = 0; k < 5; k++) begin
            cycle(20);
            pulse();
            tests_run++;
            if (BTN_RIGHT !== 1'b1 || BTN_LEFT !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_update%0d: got L%b R%b expected L0 R1", k, BTN_LEFT, BTN_RIGHT);
            end
        end
        idle_clear();
    endtask

    task automatic test_coincident();
        BTN_LEFT_RAW = 1'b1;
        cycle(9);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b1) begin
            tests_failed++;
            $display("FAIL coincident_report: got %b expected 1", BTN_LEFT);
        end
        BTN_LEFT_RAW = 1'b0;
        cycle(15);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_no_sticky: got %b expected 0", BTN_LEFT);
        end
        idle_clear();
    endtask

    task automatic test_conflict();
        BTN_LEFT_RAW  = 1'b1;
        BTN_RIGHT_RAW = 1'b1;
        cycle(12);
        pulse();
        tests_run++;
        if (BTN_LEFT !== EXP_CONFLICT || BTN_RIGHT !== EXP_CONFLICT) begin
            tests_failed++;
            $display("FAIL conflict: got %b%b expected %b%b", BTN_LEFT, BTN_RIGHT,
                     EXP_CONFLICT, EXP_CONFLICT);
        end
        idle_clear();
    endtask

    task automatic test_reset_mid();
        BTN_LEFT_RAW = 1'b1;
        cycle(6);
        RST_N = 1'b0;
        cycle(2);
        tests_run++;
        if (BTN_LEFT !== 1'b0 || BTN_RIGHT !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %b%b expected 00", BTN_LEFT, BTN_RIGHT);
        end
        BTN_LEFT_RAW = 1'b0;
        RST_N        = 1'b1;
        cycle(15);
        pulse();
        tests_run++;
        if (BTN_LEFT !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_press: got %b expected 0", BTN_LEFT);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        RST_N         = 1'b0;
        BTN_LEFT_RAW  = 1'b0;
        BTN_RIGHT_RAW = 1'b0;
        START_UPDATE  = 1'b0;
        test_reset();
        test_bounce();
        test_short_press();
        test_hold();
        test_coincident();
        test_conflict();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
